// File: rtl/spi_wrapper_monitor.sv
// ---------------------------------------------------------------------------
// spi_wrapper_monitor
//   Passive protocol monitor for the SPI wrapper bus. It samples ss_n, mosi and
//   miso in the clk domain and decodes each frame into a command and a payload.
//   For RD_DATA frames it also captures the read data the slave returns on miso.
//   Sticky error flags report short frames, illegal miso activity and RD_DATA
//   frames that are not preceded by an RD_ADDR frame. The monitor drives no
//   SPI pins.
//
//   Frame: 2 cmd bits followed by DATA_W payload bits on mosi, MSB first.
//   A RD_DATA frame continues with RD_GAP idle cycles and then DATA_W miso bits.
//
// Optional feature (build macro SPI_MON_ERR_CNT_EN):
//   defined   : err_cnt counts the cycles in which any error is detected. It
//               saturates at 16'hFFFF and is cleared by err_clr.
//   undefined : err_cnt is tied to 0 and the counter logic is not built.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   ss_n         in   slave select, active low
//   mosi         in   master-out serial data
//   miso         in   slave-out serial data
//   err_clr      in   synchronous clear of err_flags and err_cnt
//   frame_valid  out  1-cycle pulse when a complete frame has ended
//   frame_cmd    out  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//   frame_data   out  mosi payload of the last complete frame
//   rd_data      out  miso read data of the last frame (0 unless RD_DATA)
//   err_flags    out  sticky {err_seq, err_miso, err_short}
//   err_cnt      out  saturating error-cycle count (see above)
//   dbg_state    out  current FSM state encoding, for checkers
//
// Bus observation semantics: there is no valid/ready handshake here. A frame
// is "valid" from the cycle ss_n is sampled low in IDLE until ss_n is sampled
// high again. The monitor can never stall the bus; it only observes it.
// ---------------------------------------------------------------------------
module spi_wrapper_monitor #(
  parameter int DATA_W = 8,
  parameter int RD_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  input  logic              miso,
  input  logic              err_clr,
  output logic              frame_valid,
  output logic [1:0]        frame_cmd,
  output logic [DATA_W-1:0] frame_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        err_flags,
  output logic [15:0]       err_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_SHIFT    = 3'd2,
    S_GAP      = 3'd3,
    S_READ     = 3'd4,
    S_WAIT_END = 3'd5
  } state_t;

  localparam int FRAME_W = DATA_W + 2;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int RD_W    = $clog2(DATA_W + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [RD_W-1:0]  LAST_RD  = RD_W'(DATA_W - 1);
  localparam logic [3:0]       LAST_GAP = 4'(RD_GAP - 1);

  state_t state, state_nxt, prev_state;

  logic [FRAME_W-1:0] shreg;
  logic [DATA_W-1:0]  rd_shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [3:0]         gap_cnt;
  logic [RD_W-1:0]    rd_cnt;
  logic               rd_addr_pend;
  logic               miso_q;

  // Command bits as they stand just before the last mosi bit is shifted in:
  // the first two bits received sit at the top of the DATA_W+1 bits held so far.
  logic [1:0] cmd_early;
  logic [1:0] cmd_full;

  assign cmd_early = shreg[DATA_W:DATA_W-1];
  assign cmd_full  = shreg[FRAME_W-1:DATA_W];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev_state <= S_IDLE;
    end else begin
      state      <= state_nxt;
      prev_state <= state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!ss_n) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = ss_n ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (ss_n) begin
          state_nxt = S_IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          if (cmd_early == 2'b11) state_nxt = (RD_GAP == 0) ? S_READ : S_GAP;
          else                    state_nxt = S_WAIT_END;
        end
      end
      S_GAP: begin
        if (ss_n)                     state_nxt = S_IDLE;
        else if (gap_cnt == LAST_GAP) state_nxt = S_READ;
      end
      S_READ: begin
        if (ss_n)                   state_nxt = S_IDLE;
        else if (rd_cnt == LAST_RD) state_nxt = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (ss_n) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / control decode
  // -------------------------------------------------------------------------
  logic start_en;
  logic shift_en;
  logic gap_en;
  logic read_en;
  logic frame_done;
  logic err_short_det;
  logic err_miso_det;
  logic err_seq_det;
  logic first_wait;

  always_comb begin
    start_en      = 1'b0;
    shift_en      = 1'b0;
    gap_en        = 1'b0;
    read_en       = 1'b0;
    frame_done    = 1'b0;
    err_short_det = 1'b0;
    err_miso_det  = 1'b0;
    first_wait    = (state == S_WAIT_END) && (prev_state != S_WAIT_END);
    case (state)
      S_IDLE: begin
        err_miso_det = miso;
      end
      S_START: begin
        start_en      = !ss_n;
        err_short_det = ss_n;
        err_miso_det  = (miso != miso_q);
      end
      S_SHIFT: begin
        shift_en      = !ss_n;
        err_short_det = ss_n;
        err_miso_det  = (miso != miso_q);
      end
      S_GAP: begin
        gap_en        = !ss_n;
        err_short_det = ss_n;
      end
      S_READ: begin
        read_en       = !ss_n;
        err_short_det = ss_n;
      end
      S_WAIT_END: begin
        frame_done   = ss_n;
        // The slave may still be releasing miso right after the read window.
        err_miso_det = !first_wait && (miso != miso_q);
      end
      default: ;
    endcase
    err_seq_det = frame_done && (cmd_full == 2'b11) && !rd_addr_pend;
  end

  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Datapath: shift registers and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      rd_shreg <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rd_cnt   <= '0;
      miso_q   <= 1'b0;
    end else begin
      miso_q <= miso;
      if (start_en) begin
        shreg    <= '0;
        rd_shreg <= '0;
        bit_cnt  <= '0;
        gap_cnt  <= '0;
        rd_cnt   <= '0;
      end
      if (shift_en) begin
        shreg   <= {shreg[FRAME_W-2:0], mosi};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (gap_en) gap_cnt <= gap_cnt + 1'b1;
      if (read_en) begin
        rd_shreg <= {rd_shreg[DATA_W-2:0], miso};
        rd_cnt   <= rd_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame outputs and read-sequence tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid  <= 1'b0;
      frame_cmd    <= 2'b00;
      frame_data   <= '0;
      rd_data      <= '0;
      rd_addr_pend <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        frame_cmd    <= cmd_full;
        frame_data   <= shreg[DATA_W-1:0];
        rd_data      <= (cmd_full == 2'b11) ? rd_shreg : '0;
        rd_addr_pend <= (cmd_full == 2'b10);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags: a new error in the same cycle as err_clr wins.
  // -------------------------------------------------------------------------
  logic [2:0] err_det;
  assign err_det = {err_seq_det, err_miso_det, err_short_det};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_flags <= 3'b000;
    else     err_flags <= (err_flags & {3{!err_clr}}) | err_det;
  end

`ifdef SPI_MON_ERR_CNT_EN
  logic        any_err;
  logic [15:0] err_cnt_q;
  assign any_err = |err_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_cnt_q <= 16'h0000;
    else if (err_clr)                        err_cnt_q <= {15'h0000, any_err};
    else if (any_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'h0001;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_wrapper_monitor.sv
// ---------------------------------------------------------------------------
// tb_spi_wrapper_monitor
//   Directed bench for spi_wrapper_monitor (DATA_W=8, RD_GAP=1). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled 1 time unit
//   after the falling edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spi_wrapper_monitor;

  localparam int DATA_W = 8;
`ifdef SPI_MON_ERR_CNT_EN
  localparam logic [15:0] CNT_ONE = 16'h0001;
`else
  localparam logic [15:0] CNT_ONE = 16'h0000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ss_n    = 1'b1;
  logic              mosi    = 1'b0;
  logic              miso    = 1'b0;
  logic              err_clr = 1'b0;
  logic              frame_valid;
  logic [1:0]        frame_cmd;
  logic [DATA_W-1:0] frame_data;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        err_flags;
  logic [15:0]       err_cnt;
  logic [2:0]        dbg_state;

  spi_wrapper_monitor #(.DATA_W(DATA_W), .RD_GAP(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso),
    .err_clr     (err_clr),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_data  (frame_data),
    .rd_data     (rd_data),
    .err_flags   (err_flags),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always @(negedge clk) if (frame_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Drives a full frame starting from IDLE; returns right after the edge on
  // which the monitor leaves WAIT_END (frame_valid is then high).
  task automatic send_frame(input logic [1:0] cmd, input logic [7:0] data,
                            input logic [7:0] rdv);
    logic [9:0] bits;
    bits = {cmd, data};
    ss_n = 1'b0;
    step();                      // IDLE -> START
    step();                      // START -> SHIFT
    for (int i = 9; i >= 0; i--) begin
      mosi = bits[i];
      step();
    end
    mosi = 1'b0;
    if (cmd == 2'b11) begin
      step();                    // GAP -> READ
      for (int i = 7; i >= 0; i--) begin
        miso = rdv[i];
        step();
      end
      miso = 1'b0;               // released in the first WAIT_END cycle
    end
    ss_n = 1'b1;
    step();                      // WAIT_END -> IDLE
  endtask

  int p0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle bus after reset
    repeat (20) step();
    sample();
    chk("t1_flags", err_flags, 3'b000);
    chk("t1_pulses", pulses, 0);
    chk("t1_valid", frame_valid, 1'b0);
    chk("t1_cmd", frame_cmd, 2'b00);
    chk("t1_data", frame_data, 8'h00);
    chk("t1_rd", rd_data, 8'h00);
    chk("t1_cnt", err_cnt, 16'h0000);
    chk("t1_state", dbg_state, 3'd0);

    // 2: WR_ADDR 0xA5
    send_frame(2'b00, 8'hA5, 8'h00);
    sample();
    chk("t2_valid", frame_valid, 1'b1);
    chk("t2_cmd", frame_cmd, 2'b00);
    chk("t2_data", frame_data, 8'hA5);
    chk("t2_rd", rd_data, 8'h00);
    chk("t2_flags", err_flags, 3'b000);
    sample();
    chk("t2_valid_drop", frame_valid, 1'b0);
    chk("t2_data_hold", frame_data, 8'hA5);
    chk("t2_pulses", pulses, 1);

    // 3: RD_ADDR 0x03, then RD_DATA with slave data 0x3C
    send_frame(2'b10, 8'h03, 8'h00);
    sample();
    chk("t3_addr_cmd", frame_cmd, 2'b10);
    chk("t3_addr_data", frame_data, 8'h03);
    send_frame(2'b11, 8'h00, 8'h3C);
    sample();
    chk("t3_valid", frame_valid, 1'b1);
    chk("t3_cmd", frame_cmd, 2'b11);
    chk("t3_data", frame_data, 8'h00);
    chk("t3_rd", rd_data, 8'h3C);
    chk("t3_flags", err_flags, 3'b000);

    // 4: RD_DATA straight after reset -> err_seq, then err_clr
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_frame(2'b11, 8'h42, 8'h81);
    sample();
    chk("t4_valid", frame_valid, 1'b1);
    chk("t4_flags", err_flags, 3'b100);
    chk("t4_rd", rd_data, 8'h81);
    chk("t4_cnt", err_cnt, CNT_ONE);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    sample();
    chk("t4_clr_flags", err_flags, 3'b000);
    chk("t4_clr_cnt", err_cnt, 16'h0000);

    // 5: short frame after 5 SHIFT bits, then a good WR_DATA frame
    p0 = pulses;
    ss_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      step();
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    step();
    sample();
    chk("t5_short", err_flags, 3'b001);
    chk("t5_no_pulse", pulses, p0);
    chk("t5_cnt", err_cnt, CNT_ONE);
    send_frame(2'b01, 8'h5A, 8'h00);
    sample();
    chk("t5_valid", frame_valid, 1'b1);
    chk("t5_cmd", frame_cmd, 2'b01);
    chk("t5_data", frame_data, 8'h5A);
    chk("t5_rd", rd_data, 8'h00);
    chk("t5_sticky", err_flags, 3'b001);

    // 6: miso toggles during SHIFT, then async reset mid-READ
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    ss_n = 1'b0;
    step();
    step();
    for (int i = 9; i >= 0; i--) begin
      mosi = (i >= 8) ? 1'b1 : 1'b0;
      if (i == 6) miso = 1'b1;
      step();
      if (i == 6) begin
        sample();
        chk("t6_miso_flag", err_flags, 3'b010);
        chk("t6_cnt", err_cnt, CNT_ONE);
      end
    end
    mosi = 1'b0;
    step();                      // GAP -> READ
    step();
    step();
    sample();
    chk("t6_in_read", dbg_state, 3'd4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", frame_valid, 1'b0);
    chk("t6_rst_cmd", frame_cmd, 2'b00);
    chk("t6_rst_data", frame_data, 8'h00);
    chk("t6_rst_rd", rd_data, 8'h00);
    chk("t6_rst_flags", err_flags, 3'b000);
    chk("t6_rst_cnt", err_cnt, 16'h0000);
    chk("t6_rst_state", dbg_state, 3'd0);
    miso = 1'b0;
    ss_n = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
